// File: rtl/fetch_stage.sv
// fetch_stage: owns the program counter, issues sequential word fetches to a
// one-cycle-latency instruction memory and queues {pc, instr} pairs for decode.
// Optional feature macro: FETCH_BYPASS_EN. When it is defined, a response that
// arrives while the queue is empty is shown on out_* in the same cycle.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    output logic        imem_rd_en,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc
);

    localparam int            AW      = $clog2(DEPTH);
    localparam int            CW      = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [31:0]   pc_q;
    logic          inflight;
    logic [31:0]   inflight_pc;
    logic [31:0]   fifo_pc    [DEPTH];
    logic [31:0]   fifo_instr [DEPTH];
    logic [CW-1:0] count;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;

    logic          fifo_empty;
    logic          byp;
    logic          deq;
    logic          pop;
    logic          push;
    logic [CW:0]   occ;

    assign fifo_empty = (count == '0);

`ifdef FETCH_BYPASS_EN
    // The returning word is visible directly when nothing older is queued.
    assign byp = fifo_empty & inflight;
`else
    assign byp = 1'b0;
`endif

    assign out_valid = !fifo_empty | byp;
    assign deq       = out_valid & out_ready;
    // A bypassed word handed to decode never enters the queue.
    assign pop       = deq & !fifo_empty;
    assign push      = inflight & !redirect_valid & !(byp & out_ready);

    // Occupancy the queue would have next cycle if the outstanding fetch lands;
    // only issue when there is guaranteed room for one more response.
    assign occ        = {1'b0, count} + {{CW{1'b0}}, inflight} - {{CW{1'b0}}, deq};
    assign imem_rd_en = rst & !redirect_valid & (occ < {1'b0, DEPTH_C});
    assign imem_addr  = pc_q;

    // Output mux: bypassed response first, else queue head; zero when idle.
    always_comb begin
        out_pc    = '0;
        out_instr = '0;
        if (byp) begin
            out_pc    = inflight_pc;
            out_instr = imem_rdata;
        end else if (!fifo_empty) begin
            out_pc    = fifo_pc[rd_ptr];
            out_instr = fifo_instr[rd_ptr];
        end
    end

    // Control state: PC, in-flight flag and queue pointers; redirect flushes all.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q     <= RESET_PC;
            inflight <= 1'b0;
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
        end else if (redirect_valid) begin
            pc_q     <= redirect_pc & 32'hFFFF_FFFC;
            inflight <= 1'b0;
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
        end else begin
            if (imem_rd_en) begin
                pc_q <= pc_q + 32'd4;
            end
            inflight <= imem_rd_en;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Data path: remember the fetched PC and store responses; no reset needed
    // because every read of this storage is qualified by control state.
    always_ff @(posedge clk) begin
        if (imem_rd_en) begin
            inflight_pc <= pc_q;
        end
        if (push) begin
            fifo_pc[wr_ptr]    <= inflight_pc;
            fifo_instr[wr_ptr] <= imem_rdata;
        end
    end

    // The issue rule makes a push into a full queue unreachable; flag it if not.
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
        !(push && (count == DEPTH_C)));

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: scoreboard bench for fetch_stage. Expected PCs are queued when
// the bench starts or redirects the stream and popped on each decode handshake.
module tb_fetch_stage;

    localparam logic [31:0] RPC = 32'h0000_0100;
    localparam logic [31:0] KEY = 32'hA5A5_0000;
`ifdef FETCH_BYPASS_EN
    localparam int EXP_LAT = 1;
`else
    localparam int EXP_LAT = 2;
`endif

    logic        clk;
    logic        rst;
    logic [31:0] imem_addr;
    logic        imem_rd_en;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;

    int nchk;
    int nfail;
    logic [31:0] exp_q[$];

    fetch_stage #(.RESET_PC(RPC), .DEPTH(2)) dut (
        .clk           (clk),
        .rst           (rst),
        .imem_addr     (imem_addr),
        .imem_rd_en    (imem_rd_en),
        .imem_rdata    (imem_rdata),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_instr     (out_instr),
        .out_pc        (out_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous instruction memory: word = address ^ KEY, one-cycle latency.
    always @(posedge clk) begin
        imem_rdata <= imem_rd_en ? (imem_addr ^ KEY) : 32'hDEAD_BEEF;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Called at a falling edge: sample a pending handshake, then advance one cycle.
    task automatic cyc();
        logic [31:0] e;
        #1;
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected_out", 32'(exp_q.size()), 32'd1);
            end else begin
                e = exp_q.pop_front();
                check("out_pc", out_pc, e);
                check("out_instr", out_instr, e ^ KEY);
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic push_seq(input logic [31:0] start, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(start + 32'(4 * i));
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            cyc();
            n++;
        end
        check(tag, 32'(exp_q.size()), 32'd0);
        out_ready = 1'b0;
    endtask

    task automatic wait_valid(input string tag, input int start_lat);
        int lat;
        lat = start_lat;
        while (!out_valid && lat < 10) begin
            cyc();
            lat++;
        end
        check(tag, 32'(lat), 32'(EXP_LAT));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        nchk = 0;
        nfail = 0;
        rst = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        out_ready = 1'b1;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_rd_en", imem_rd_en, 1'b0);
        check("rst_out_pc", out_pc, 32'h0);
        check("rst_out_instr", out_instr, 32'h0);

        // Startup: first fetch right after release, sustained one per cycle
        push_seq(RPC, 12);
        rst = 1'b1;
        #1;
        check("first_rd_en", imem_rd_en, 1'b1);
        check("first_addr", imem_addr, RPC);
        wait_valid("startup_latency", 0);
        for (int i = 0; i < 8; i++) begin
            check("tput_valid", out_valid, 1'b1);
            cyc();
        end

        // Backpressure: output holds, fetching stops, then resumes in order
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc();
            check("hold_valid", out_valid, 1'b1);
            check("hold_pc", out_pc, exp_q[0]);
            check("hold_instr", out_instr, exp_q[0] ^ KEY);
        end
        check("stall_rd_en", imem_rd_en, 1'b0);
        out_ready = 1'b1;
        drain("bp_drain");

        // Redirect mid-stream; the pair handshaken in the redirect cycle is kept
        push_seq(RPC + 32'h30, 4);
        out_ready = 1'b1;
        cyc();
        cyc();
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_2003;
        cyc();
        redirect_valid = 1'b0;
        exp_q.delete();
        push_seq(32'h0000_2000, 5);
        drain("redir_drain");

        // Redirect while the queue is full and decode is stalled
        for (int i = 0; i < 4; i++) cyc();
        check("full_valid", out_valid, 1'b1);
        check("full_rd_en", imem_rd_en, 1'b0);
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0040;
        cyc();
        redirect_valid = 1'b0;
        push_seq(32'h0000_0040, 4);
        #1;
        check("flush_valid", out_valid, 1'b0);
        check("tgt_rd_en", imem_rd_en, 1'b1);
        check("tgt_addr", imem_addr, 32'h0000_0040);
        out_ready = 1'b1;
        wait_valid("redirect_latency", 0);
        drain("stall_redir_drain");

        // PC wrap through the top of the address space
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFF8;
        cyc();
        redirect_valid = 1'b0;
        exp_q.delete();
        push_seq(32'hFFFF_FFF8, 4);
        out_ready = 1'b1;
        drain("wrap_drain");

        // Asynchronous reset between edges with entries queued
        for (int i = 0; i < 3; i++) cyc();
        check("pre_reset_valid", out_valid, 1'b1);
        #2;
        rst = 1'b0;
        #1;
        check("async_rst_valid", out_valid, 1'b0);
        check("async_rst_pc", out_pc, 32'h0);
        check("async_rst_rd_en", imem_rd_en, 1'b0);
        @(negedge clk);
        @(negedge clk);
        exp_q.delete();
        push_seq(RPC, 4);
        rst = 1'b1;
        #1;
        check("restart_valid", out_valid, 1'b0);
        check("restart_addr", imem_addr, RPC);
        out_ready = 1'b1;
        wait_valid("restart_latency", 0);
        drain("restart_drain");

        $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
        $finish;
    end

endmodule
